// File: rtl/hex_display_bank.sv
// Registered N-digit seven-segment driver with blanking, blinking and
// leading-zero suppression for common-anode (active-low) HEX displays.
module hex_display_bank #(
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic                    lz_en,
    output logic [7*N_DIGITS-1:0]   display,
    output logic                    blink_phase
);

    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
    localparam logic [6:0] DARK = 7'h7F;

    logic [4*N_DIGITS-1:0] value_q, value_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [7*N_DIGITS-1:0] display_q, display_d;
    logic [N_DIGITS-1:0]   lz;

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        value_d       = load ? value : value_q;
        cnt_d         = cnt_q + CW'(1);
        blink_phase_d = blink_phase_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d         = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Zero run is scanned from the top digit down; digit 0 always shows.
    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run = run && (value_q[4*i +: 4] == 4'h0);
            lz[i] = run && (i != 0);
        end
    end

    always_comb begin
        display_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (blank_mask[i])
                display_d[7*i +: 7] = DARK;
            else if (lz_en && lz[i])
                display_d[7*i +: 7] = DARK;
            else if (blink_mask[i] && blink_phase_q)
                display_d[7*i +: 7] = DARK;
            else
                display_d[7*i +: 7] = seg(value_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value_q       <= '0;
            cnt_q         <= '0;
            blink_phase_q <= 1'b0;
            display_q     <= '1;
        end else begin
            value_q       <= value_d;
            cnt_q         <= cnt_d;
            blink_phase_q <= blink_phase_d;
            display_q     <= display_d;
        end
    end

    assign display     = display_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank with 4 digits and a 4-cycle blink.
module tb_hex_display_bank;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic        lz_en = 1'b0;
    logic [27:0] display;
    logic        blink_phase;

    int checks = 0;
    int failures = 0;

    hex_display_bank #(.N_DIGITS(4), .BLINK_DIV(4)) dut (
        .clock(clock),
        .resetn(resetn),
        .load(load),
        .value(value),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .lz_en(lz_en),
        .display(display),
        .blink_phase(blink_phase)
    );

    always #5 clock = ~clock;

    function automatic logic [27:0] d4(input logic [6:0] a, b, c, e);
        return {a, b, c, e};
    endfunction

    task automatic check(input string tag, input logic [27:0] obs,
                         input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [12:0] ph_tab;
    logic [12:0] dk_tab;
    logic [27:0] exp_disp;

    initial begin
        // Reset asserted between edges takes effect at once
        #2 resetn = 1'b0;
        #1;
        check("rst_disp", display, 28'hFFFFFFF);
        check("rst_phase", {27'd0, blink_phase}, 28'd0);
        tick();
        check("rst_hold", display, 28'hFFFFFFF);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        check("rel_zero", display, d4(7'h40, 7'h40, 7'h40, 7'h40));

        // Load latency: captured at edge k, shown after k+1
        value = 16'h1A3F;
        load = 1'b1;
        tick();
        check("load_k", display, d4(7'h40, 7'h40, 7'h40, 7'h40));
        load = 1'b0;
        tick();
        check("load_k1", display, d4(7'h79, 7'h08, 7'h30, 7'h0E));

        // Leading-zero suppression
        value = 16'h0040;
        load = 1'b1;
        lz_en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("lz_0040", display, d4(7'h7F, 7'h7F, 7'h19, 7'h40));
        value = 16'h0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("lz_0000", display, d4(7'h7F, 7'h7F, 7'h7F, 7'h40));
        lz_en = 1'b0;
        tick();
        check("lz_off", display, d4(7'h40, 7'h40, 7'h40, 7'h40));

        // Blanked nonzero top digit still ends the zero run
        value = 16'h8000;
        load = 1'b1;
        lz_en = 1'b1;
        blank_mask = 4'b1000;
        tick();
        load = 1'b0;
        tick();
        check("prio_blank", display, d4(7'h7F, 7'h40, 7'h40, 7'h40));
        blank_mask = 4'b0000;
        tick();
        check("prio_unblank", display, d4(7'h00, 7'h40, 7'h40, 7'h40));
        lz_en = 1'b0;

        // Blinking with a loaded value, then reset mid-run
        value = 16'h1234;
        load = 1'b1;
        blink_mask = 4'b0001;
        tick();
        load = 1'b0;
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_disp", display, 28'hFFFFFFF);
        check("mid_rst_phase", {27'd0, blink_phase}, 28'd0);
        @(negedge clock);
        resetn = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("post_e1", display, d4(7'h40, 7'h40, 7'h40, 7'h40));

        // Edge e=1..13 after release, bit index e-1
        ph_tab = 13'b1100001111000;
        dk_tab = 13'b1000011110000;
        check("post_ph1", {27'd0, blink_phase}, {27'd0, ph_tab[0]});
        for (int e = 2; e <= 13; e++) begin
            tick();
            exp_disp = d4(7'h79, 7'h24, 7'h30,
                          dk_tab[e-1] ? 7'h7F : 7'h19);
            check($sformatf("blink_disp_e%0d", e), display, exp_disp);
            check($sformatf("blink_ph_e%0d", e), {27'd0, blink_phase},
                  {27'd0, ph_tab[e-1]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
